hazard_scoreboard_unit: RTL and testbench

- Parametrised successor of the single-cycle load-use hazard detector, for the deeper pipeline with variable-latency loads and a multi-cycle multiply/divide unit.
- Keeps a per-register scoreboard of pending long-latency writes and generates ID-stage stall and EX-stage redirect flush.
- Also provides saturating stall/flush performance counters.
- Sits beside the ID/EX pipeline register; its stall freezes PC and IF/ID, and its flush bubbles IF/ID and ID/EX.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_scoreboard_unit_cnt.sv | 29 ++
 rtl/hazard_scoreboard_unit.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: producer-class encodings,
// default latencies and the latency-counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_MULDIV = 2'd2,
    CLS_RSVD   = 2'd3
  } cls_e;

  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MD_LAT   = 4;

  // One bit per hazard reason seen by the instruction in ID.
  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
    logic md_struct;
  } hazard_t;

  // Width needed to hold the larger of the two latencies.
  function automatic int cnt_width(input int load_lat, input int md_lat);
    int m;
    m = (load_lat > md_lat) ? load_lat : md_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_cnt.sv
// Loadable down-counter that stops at zero; busy while nonzero.
// Used once per tracked register and once for the mul/div unit.
module sb_latency_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard unit: tracks pending long-latency writes per
// register, raises ID stall / EX redirect flush and counts both events.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int MD_LAT   = DEF_MD_LAT,
  parameter int PCW      = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_we,
  input  logic [1:0]      id_class,
  input  logic            ex_branch_taken,
  input  logic            ex_jump,
  output logic            stall,
  output logic            flush,
  output logic            md_busy,
  output logic [NREG-1:0] busy_vec,
  output logic [PCW-1:0]  stall_cnt,
  output logic [PCW-1:0]  flush_cnt
);

  localparam int            CW       = cnt_width(LOAD_LAT, MD_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MD_VAL   = CW'(MD_LAT);

  hazard_t       hz;
  logic          cls_load;
  logic          cls_md;
  logic          issue;
  logic          rd_load;
  logic          md_load;
  logic [CW-1:0] rd_val;

  assign cls_load = (id_class == CLS_LOAD);
  assign cls_md   = (id_class == CLS_MULDIV);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hz           = '0;
    hz.raw1      = id_rs1_used && (id_rs1 != '0) && busy_vec[id_rs1];
    hz.raw2      = id_rs2_used && (id_rs2 != '0) && busy_vec[id_rs2];
    hz.waw       = id_we && (id_rd != '0) && busy_vec[id_rd];
    hz.md_struct = cls_md && md_busy;
  end

  // A redirect outranks any hazard: the ID instruction is squashed anyway.
  assign flush = ex_branch_taken | ex_jump;
  assign stall = id_valid & ~flush & (|hz);
  assign issue = id_valid & ~stall & ~flush;

  // ALU and reserved-class producers are covered by forwarding.
  assign rd_load = issue & id_we & (id_rd != '0) & (cls_load | cls_md);
  assign md_load = issue & cls_md;
  assign rd_val  = cls_md ? MD_VAL : LOAD_VAL;

  assign busy_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    sb_latency_cnt #(
      .CW(CW)
    ) u_cnt (
      .clk     (cpu_clk),
      .rst     (cpu_rst),
      .load    (rd_load && (id_rd == AW'(i))),
      .load_val(rd_val),
      .busy    (busy_vec[i])
    );
  end

  sb_latency_cnt #(
    .CW(CW)
  ) u_md_cnt (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .load    (md_load),
    .load_val(MD_VAL),
    .busy    (md_busy)
  );

  // Performance counters hold at all-ones instead of wrapping.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PCW'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      flush_cnt <= '0;
    end else if (flush && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + PCW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed vector table,
// multi-cycle corner sequences and random traffic against a ready-time model.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 1;
  localparam int MD_LAT   = 4;
  localparam int PCW      = 4;
  localparam int CNT_MAX  = (1 << PCW) - 1;

  logic            cpu_clk = 1'b0;
  logic            cpu_rst;
  logic            id_valid;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [AW-1:0]   id_rd;
  logic            id_we;
  logic [1:0]      id_class;
  logic            ex_branch_taken;
  logic            ex_jump;
  logic            stall;
  logic            flush;
  logic            md_busy;
  logic [NREG-1:0] busy_vec;
  logic [PCW-1:0]  stall_cnt;
  logic [PCW-1:0]  flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard_unit #(
    .NREG(NREG), .AW(AW), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT), .PCW(PCW)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_class       (id_class),
    .ex_branch_taken(ex_branch_taken),
    .ex_jump        (ex_jump),
    .stall          (stall),
    .flush          (flush),
    .md_busy        (md_busy),
    .busy_vec       (busy_vec),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic            valid;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            u1;
    logic            u2;
    logic [AW-1:0]   rd;
    logic            we;
    logic [1:0]      cls;
    logic            br;
    logic            jmp;
    logic            e_stall;
    logic            e_flush;
    logic            e_md;
    logic [NREG-1:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: absolute cycle at which each pending write becomes forwardable.
  int cyc = 0;
  int rdy[NREG];
  int md_rdy;
  int m_sc;
  int m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREG-1:0] bit_of(input int n);
    logic [NREG-1:0] b;
    b = '0;
    if (n >= 0) b[n] = 1'b1;
    return b;
  endfunction

  function automatic vec_t mk(input logic v, input int r1, input int r2, input logic u1,
                              input logic u2, input int rd, input logic we, input logic [1:0] cls,
                              input logic br, input logic jmp, input logic es, input logic ef,
                              input logic emd, input int busy_reg);
    vec_t t;
    t.valid = v;        t.rs1 = AW'(r1);   t.rs2 = AW'(r2);
    t.u1 = u1;          t.u2 = u2;         t.rd = AW'(rd);
    t.we = we;          t.cls = cls;       t.br = br;     t.jmp = jmp;
    t.e_stall = es;     t.e_flush = ef;    t.e_md = emd;
    t.e_busy = bit_of(busy_reg);
    return t;
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic u1, input logic u2, input logic [AW-1:0] rd, input logic we,
                       input logic [1:0] cls, input logic br, input logic jmp);
    id_valid = v;   id_rs1 = r1;   id_rs2 = r2;
    id_rs1_used = u1;  id_rs2_used = u2;
    id_rd = rd;     id_we = we;    id_class = cls;
    ex_branch_taken = br;  ex_jump = jmp;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive_idle();
    cpu_rst = 1'b1;
    repeat (2) next_cycle();
    cpu_rst = 1'b0;
    for (int i = 0; i < NREG; i++) rdy[i] = 0;
    md_rdy = 0;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic rand_cycle(input int idx);
    logic v, u1, u2, we, br, jmp;
    logic [AW-1:0] r1, r2, rd;
    logic [1:0] cls;
    logic [NREG-1:0] e_busy;
    logic e_md, e_flush, e_stall, e_issue, haz;
    v   = ($urandom % 8) != 0;
    r1  = AW'($urandom % 8);
    r2  = AW'($urandom % 8);
    rd  = AW'($urandom % 8);
    u1  = 1'($urandom % 2);
    u2  = 1'($urandom % 2);
    we  = 1'($urandom % 2);
    cls = 2'($urandom % 4);
    br  = ($urandom % 10) == 0;
    jmp = ($urandom % 12) == 0;
    drive(v, r1, r2, u1, u2, rd, we, cls, br, jmp);

    e_busy = '0;
    for (int i = 1; i < NREG; i++) e_busy[i] = (cyc < rdy[i]);
    e_md    = (cyc < md_rdy);
    e_flush = br | jmp;
    haz     = (u1 && r1 != 0 && e_busy[r1]) || (u2 && r2 != 0 && e_busy[r2]) ||
              (we && rd != 0 && e_busy[rd]) || (cls == 2'd2 && e_md);
    e_stall = v && !e_flush && haz;
    e_issue = v && !e_stall && !e_flush;

    #3;
    check($sformatf("rand%0d stall", idx), 64'(stall), 64'(e_stall));
    check($sformatf("rand%0d flush", idx), 64'(flush), 64'(e_flush));
    check($sformatf("rand%0d md_busy", idx), 64'(md_busy), 64'(e_md));
    check($sformatf("rand%0d busy_vec", idx), 64'(busy_vec), 64'(e_busy));
    check($sformatf("rand%0d stall_cnt", idx), 64'(stall_cnt), 64'(m_sc));
    check($sformatf("rand%0d flush_cnt", idx), 64'(flush_cnt), 64'(m_fc));

    if (e_stall && m_sc < CNT_MAX) m_sc++;
    if (e_flush && m_fc < CNT_MAX) m_fc++;
    if (e_issue) begin
      if (cls == 2'd1 && we && rd != 0) rdy[rd] = cyc + 1 + LOAD_LAT;
      if (cls == 2'd2) begin
        md_rdy = cyc + 1 + MD_LAT;
        if (we && rd != 0) rdy[rd] = cyc + 1 + MD_LAT;
      end
    end
    next_cycle();
  endtask

  initial begin
    drive_idle();
    cpu_rst = 1'b1;
    #3;
    check("reset stall", 64'(stall), 64'(0));
    check("reset flush", 64'(flush), 64'(0));
    check("reset md_busy", 64'(md_busy), 64'(0));
    check("reset busy_vec", 64'(busy_vec), 64'(0));
    check("reset stall_cnt", 64'(stall_cnt), 64'(0));
    check("reset flush_cnt", 64'(flush_cnt), 64'(0));
    do_reset();

    // Directed table: load-use, mul/div RAW and structural, flush priority,
    // x0 and unused sources, WAW, valid=0, reserved class.
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, CLS_LOAD,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, CLS_ALU,    0, 0, 1, 0, 0,  5));
    tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, CLS_ALU,    0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, CLS_MULDIV, 0, 0, 0, 0, 0, -1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 1, 7, 1, 1, 12, 1, CLS_ALU, 0, 0, 1, 0, 1, 7));
    tbl.push_back(mk(1, 1, 7, 1, 1, 12, 1, CLS_ALU,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, CLS_MULDIV, 0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, CLS_ALU,    0, 0, 0, 0, 1,  8));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, CLS_MULDIV, 0, 0, 1, 0, 1, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, CLS_MULDIV, 0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, CLS_ALU,   1, 0, 0, 1, 1,  9));
    tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, CLS_ALU,   0, 1, 0, 1, 1,  9));
    tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, CLS_ALU,   0, 0, 1, 0, 1,  9));
    tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, CLS_ALU,   0, 0, 1, 0, 1,  9));
    tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, CLS_ALU,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, CLS_LOAD,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 14, 1, CLS_ALU,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, CLS_LOAD,  0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 10, 0, 0, 1, 11, 1, CLS_ALU,  0, 0, 0, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, CLS_ALU,    0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, CLS_MULDIV, 0, 0, 0, 0, 0, -1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, CLS_LOAD, 0, 0, 1, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, CLS_LOAD,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(0, 3, 3, 1, 1, 3, 1, CLS_MULDIV, 0, 0, 0, 0, 0,  3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, CLS_ALU,    0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, CLS_RSVD,   0, 0, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, CLS_ALU,    0, 0, 0, 0, 0, -1));

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].we, tbl[i].cls, tbl[i].br, tbl[i].jmp);
      #3;
      check($sformatf("row%0d stall", i), 64'(stall), 64'(tbl[i].e_stall));
      check($sformatf("row%0d flush", i), 64'(flush), 64'(tbl[i].e_flush));
      check($sformatf("row%0d md_busy", i), 64'(md_busy), 64'(tbl[i].e_md));
      check($sformatf("row%0d busy_vec", i), 64'(busy_vec), 64'(tbl[i].e_busy));
      next_cycle();
    end
    #3;
    check("table stall_cnt", 64'(stall_cnt), 64'(14));
    check("table flush_cnt", 64'(flush_cnt), 64'(2));

    // Back-to-back MULs with rd=x0: each one waits 4 cycles on md_busy;
    // 20 stall cycles in total saturate the 4-bit counter at 15.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b1, CLS_MULDIV, 1'b0, 1'b0);
      #3;
      check($sformatf("sat%0d stall", k), 64'(stall), 64'((k % 5) != 0));
      next_cycle();
    end
    drive_idle();
    #3;
    check("sat stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    check("sat busy_vec", 64'(busy_vec), 64'(0));

    // Asynchronous reset in the middle of a pending write.
    do_reset();
    drive(1'b1, '0, '0, 1'b0, 1'b0, AW'(5), 1'b1, CLS_MULDIV, 1'b0, 1'b0);
    #3;
    check("arst issue stall", 64'(stall), 64'(0));
    next_cycle();
    drive(1'b1, AW'(5), '0, 1'b1, 1'b0, AW'(6), 1'b1, CLS_ALU, 1'b0, 1'b0);
    #3;
    check("arst dep stall", 64'(stall), 64'(1));
    next_cycle();
    #1;
    check("arst pre stall_cnt", 64'(stall_cnt), 64'(1));
    check("arst pre busy_vec", 64'(busy_vec), 64'(bit_of(5)));
    cpu_rst = 1'b1;
    #1;
    check("arst busy_vec", 64'(busy_vec), 64'(0));
    check("arst stall", 64'(stall), 64'(0));
    check("arst md_busy", 64'(md_busy), 64'(0));
    check("arst stall_cnt", 64'(stall_cnt), 64'(0));
    next_cycle();
    cpu_rst = 1'b0;

    // Random traffic against the model, with periodic resets.
    for (int blk = 0; blk < 12; blk++) begin
      do_reset();
      for (int c = 0; c < 50; c++) rand_cycle(blk * 50 + c);
    end

    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
